uart_tx_mmio: RTL

Memory-mapped UART transmitter on the CPU data-memory bus, downstream of the MEM stage. It decodes its own address window, accepts byte writes into a small transmit FIFO and serializes them 8N1 on `tx`. Status and divisor registers are readable with one-cycle registered read latency, matching the BRAM read timing the MEM/WB path already assumes.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/sync_fifo.sv | 45 ++++
 rtl/uart_tx_mmio.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared CPU-side constants and types; this slice carries the UART register map.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ALEN = 32;

  localparam logic [ALEN-1:0] UART_BASE       = 32'h8000_0010;
  localparam logic [3:0]      UART_TXDATA_OFF = 4'h0;
  localparam logic [3:0]      UART_STATUS_OFF = 4'h4;
  localparam logic [3:0]      UART_DIV_OFF    = 4'h8;

  typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; pop is ignored when empty,
// push is ignored when full unless a pop frees the slot the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO and the
// frame FSM with its baud counter. Reads have one cycle of latency.
module uart_tx_mmio
  import riscv_pkg::*;
#(
  parameter logic [ALEN-1:0] BASE_ADDR    = UART_BASE,
  parameter logic [15:0]     CLKS_PER_BIT = 16'd868,
  parameter int              FIFO_DEPTH   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ALEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_we,
  input  logic [3:0]      dmem_be,
  output logic [XLEN-1:0] rdata,
  output logic            hit,
  output logic            tx,
  output uart_state_t     dbg_state
);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]      off;
  logic            wr_txdata, wr_status, wr_div;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;
  logic [CNTW-1:0] fifo_count;
  logic            overflow;
  logic [15:0]     div_reg, div_new, div_q, baud_cnt;
  logic            bit_end;
  uart_state_t     state;
  logic [7:0]      shift;
  logic [2:0]      bit_idx;
  logic [XLEN-1:0] rd_mux;
  logic            unused_bits;

  // The window spans 16 bytes; offset +12 decodes as a hit but maps to nothing.
  assign hit       = (dmem_addr[ALEN-1:4] == BASE_ADDR[ALEN-1:4]);
  assign off       = {dmem_addr[3:2], 2'b00};
  assign wr_txdata = hit & dmem_we & dmem_be[0] & (off == UART_TXDATA_OFF);
  assign wr_status = hit & dmem_we & dmem_be[0] & (off == UART_STATUS_OFF);
  assign wr_div    = hit & dmem_we & (|dmem_be[1:0]) & (off == UART_DIV_OFF);
  assign div_new   = {dmem_be[1] ? dmem_wdata[15:8] : div_reg[15:8],
                      dmem_be[0] ? dmem_wdata[7:0]  : div_reg[7:0]};

  assign bit_end   = (baud_cnt == 16'd0);
  assign fifo_pop  = ~fifo_empty & ((state == UART_IDLE) | ((state == UART_STOP) & bit_end));
  assign fifo_push = wr_txdata & (~fifo_full | fifo_pop);
  assign dbg_state = state;
  assign unused_bits = ^{dmem_addr[1:0], dmem_wdata[31:16], dmem_be[3:2]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (dmem_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rd_mux = '0;
    case (off)
      UART_STATUS_OFF: begin
        rd_mux[0]           = (state != UART_IDLE);
        rd_mux[1]           = fifo_full;
        rd_mux[2]           = fifo_empty;
        rd_mux[3]           = overflow;
        rd_mux[8 +: CNTW]   = fifo_count;
      end
      UART_DIV_OFF: rd_mux[15:0] = div_reg;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      div_reg  <= CLKS_PER_BIT;
      rdata    <= '0;
    end else begin
      if (wr_txdata & fifo_full & ~fifo_pop) overflow <= 1'b1;
      else if (wr_status & dmem_wdata[3])    overflow <= 1'b0;
      if (wr_div && (div_new > 16'd1)) div_reg <= div_new;
      rdata <= hit ? rd_mux : '0;
    end
  end

  // div_q is captured at every frame start so a DIV write only affects later frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= UART_IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      div_q    <= CLKS_PER_BIT;
    end else begin
      if (state != UART_IDLE) baud_cnt <= bit_end ? div_q - 16'd1 : baud_cnt - 16'd1;
      case (state)
        UART_IDLE: begin
          if (fifo_pop) begin
            state    <= UART_START;
            tx       <= 1'b0;
            shift    <= fifo_dout;
            div_q    <= div_reg;
            baud_cnt <= div_reg - 16'd1;
          end
        end
        UART_START: begin
          if (bit_end) begin
            state   <= UART_DATA;
            tx      <= shift[0];
            bit_idx <= 3'd0;
          end
        end
        UART_DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
              state <= UART_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end
        end
        UART_STOP: begin
          if (bit_end) begin
            if (fifo_pop) begin
              state    <= UART_START;
              tx       <= 1'b0;
              shift    <= fifo_dout;
              div_q    <= div_reg;
              baud_cnt <= div_reg - 16'd1;
            end else begin
              state    <= UART_IDLE;
              baud_cnt <= 16'd0;
            end
          end
        end
        default: state <= UART_IDLE;
      endcase
    end
  end
endmodule
